// File: rtl/axil_multi_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : axil_multi_adder                                            |
// | Description: AXI4-Lite slave with NUM_CH add/subtract channels           |
// |              (A, B, RESULT, CTRL{FLAG,MODE}); ADDER_SAT_EN saturates.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module axil_multi_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CH_W   = ADDR_WIDTH - 4;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } wstate_e;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] a_q [NUM_CH];
  logic [DATA_WIDTH-1:0] a_d [NUM_CH];
  logic [DATA_WIDTH-1:0] b_q [NUM_CH];
  logic [DATA_WIDTH-1:0] b_d [NUM_CH];
  logic [DATA_WIDTH-1:0] res_q [NUM_CH];
  logic [DATA_WIDTH-1:0] res_d [NUM_CH];
  logic [NUM_CH-1:0]     mode_q, mode_d, flag_q, flag_d, pend_q, pend_d;

  logic                  aw_fire, w_fire, ar_fire, commit, wr_err;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [1:0]            rd_resp;
  logic                  unused_addr_lsbs;

  function automatic logic [CH_W:0] ch_of(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr[ADDR_WIDTH-1:4]};
  endfunction

  function automatic logic ch_hit(input logic [ADDR_WIDTH-1:0] addr, input int c);
    return ch_of(addr) == (CH_W+1)'(c);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                 input logic [DATA_WIDTH-1:0] new_v,
                                                 input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Top bit of the widened sum/difference is the carry (add) or borrow (sub).
  function automatic logic [DATA_WIDTH:0] calc(input logic [DATA_WIDTH-1:0] a,
                                               input logic [DATA_WIDTH-1:0] b,
                                               input logic                  sub);
    logic [DATA_WIDTH:0] r;
    r = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
`ifdef ADDER_SAT_EN
    if (r[DATA_WIDTH]) r[DATA_WIDTH-1:0] = sub ? '0 : '1;
`endif
    return r;
  endfunction

  assign s1_axi_awready = (wstate_q == W_IDLE) && !aw_held_q;
  assign s1_axi_wready  = (wstate_q == W_IDLE) && !w_held_q;
  assign s1_axi_bvalid  = (wstate_q == W_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = (rstate_q == R_IDLE) && (pend_q == '0);
  assign s1_axi_rvalid  = (rstate_q == R_DATA);
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;
  assign unused_addr_lsbs = &{1'b0, wr_addr[1:0], s1_axi_araddr[1:0]};

  // Write channel: AW and W may arrive in any order; commit once both are held.
  always_comb begin
    aw_fire   = s1_axi_awvalid && s1_axi_awready;
    w_fire    = s1_axi_wvalid && s1_axi_wready;
    wr_addr   = aw_held_q ? awaddr_q : s1_axi_awaddr;
    wr_data   = w_held_q ? wdata_q : s1_axi_wdata;
    wr_strb   = w_held_q ? wstrb_q : s1_axi_wstrb;
    commit    = (wstate_q == W_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    wr_err    = (ch_of(wr_addr) >= (CH_W+1)'(NUM_CH)) || (wr_addr[3:2] == 2'd2);
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (commit) begin
          wstate_d  = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_err ? 2'b10 : 2'b00;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awaddr_d  = s1_axi_awaddr;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = s1_axi_wdata;
            wstrb_d  = s1_axi_wstrb;
          end
        end
      end
      default: begin
        if (s1_axi_bready) begin
          wstate_d = W_IDLE;
          bresp_d  = 2'b00;
        end
      end
    endcase
  end

  // Channel registers and one-cycle deferred result update.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    mode_d = mode_q;
    flag_d = flag_q;
    pend_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_q[c]) {flag_d[c], res_d[c]} = calc(a_q[c], b_q[c], mode_q[c]);
      if (commit && !wr_err && ch_hit(wr_addr, c)) begin
        pend_d[c] = 1'b1;
        case (wr_addr[3:2])
          2'd0:    a_d[c] = merge(a_q[c], wr_data, wr_strb);
          2'd1:    b_d[c] = merge(b_q[c], wr_data, wr_strb);
          2'd3:    if (wr_strb[0]) mode_d[c] = wr_data[0];
          default: ;
        endcase
      end
    end
  end

  // Read channel.
  always_comb begin
    ar_fire = s1_axi_arvalid && s1_axi_arready;
    rd_data = '0;
    rd_resp = 2'b10;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit(s1_axi_araddr, c)) begin
        rd_resp = 2'b00;
        case (s1_axi_araddr[3:2])
          2'd0:    rd_data = a_q[c];
          2'd1:    rd_data = b_q[c];
          2'd2:    rd_data = res_q[c];
          default: rd_data = DATA_WIDTH'({flag_q[c], mode_q[c]});
        endcase
      end
    end
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_fire) begin
          rstate_d = R_DATA;
          rdata_d  = rd_data;
          rresp_d  = rd_resp;
        end
      end
      default: begin
        if (s1_axi_rready) rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      mode_q    <= '0;
      flag_q    <= '0;
      pend_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        a_q[c]   <= '0;
        b_q[c]   <= '0;
        res_q[c] <= '0;
      end
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      mode_q    <= mode_d;
      flag_q    <= flag_d;
      pend_q    <= pend_d;
      for (int c = 0; c < NUM_CH; c++) begin
        a_q[c]   <= a_d[c];
        b_q[c]   <= b_d[c];
        res_q[c] <= res_d[c];
      end
    end
  end

endmodule
`default_nettype wire
